mem_arbiter: RTL and testbench

- Shares the single on-chip 16-bit program/data memory between two requesters: the SLC-3 core (cpu port) and a debug/loader engine (dbg port).
- Two-way round-robin arbitration; latches the winning request and drives the memory enable/write strobes.
- Times the fixed read latency and returns data with a four-phase req/ready handshake.
- Sits between cpu/debug logic and the memory, replacing the ad-hoc ready counter at the top level.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 19 +
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   // Latency counter width; covers RD_LATENCY values 1..7
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DBG = 1'b1
   } owner_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick, combinational
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

   // A lone requester always wins; on a tie the side that did not win last time goes
   always_comb begin
      valid  = req0 | req1;
      winner = req1;
      if (req0 && req1) begin
         winner = ~last;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - cpu/debug round-robin arbiter for the shared program/data memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_mem_ena,
   output logic                  mem_wr_ena,
   output logic                  busy,
   output logic                  grant_owner
);

   localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY);
   localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(1);

   arb_state_t            state;
   owner_t                last_owner;
   logic                  lat_we;
   logic [CNT_W-1:0]      cnt;

   logic                  pick_valid;
   logic                  pick_winner;
   logic                  last_is_dbg;
   owner_t                pick_owner;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  owner_req;

   assign last_is_dbg = (last_owner == OWNER_DBG);
   assign pick_owner  = owner_t'(pick_winner);
   assign grant_owner = last_is_dbg;

   rr_pick2 u_pick (
      .req0   (cpu_req),
      .req1   (dbg_req),
      .last   (last_is_dbg),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // Route the winning requester's command toward the latch registers
   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (pick_owner == OWNER_DBG) begin
         sel_we    = dbg_we;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

   // Request level of whichever port currently owns the memory
   always_comb begin
      owner_req = cpu_req;
      if (last_is_dbg) begin
         owner_req = dbg_req;
      end
   end

   // Arbitration FSM: grant and latch, time the access, then hold ready until req drops
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         last_owner  <= OWNER_DBG;
         lat_we      <= 1'b0;
         cnt         <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_mem_ena <= 1'b0;
         mem_wr_ena  <= 1'b0;
         cpu_ready   <= 1'b0;
         dbg_ready   <= 1'b0;
         cpu_rdata   <= '0;
         dbg_rdata   <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  last_owner  <= pick_owner;
                  lat_we      <= sel_we;
                  mem_addr    <= sel_addr;
                  mem_wdata   <= sel_wdata;
                  mem_mem_ena <= 1'b1;
                  mem_wr_ena  <= sel_we;
                  cnt         <= sel_we ? WR_CNT : RD_CNT;
                  busy        <= 1'b1;
                  state       <= ACCESS;
               end
            end

            ACCESS: begin
               // A write strobe lasts only the first access cycle
               mem_wr_ena <= 1'b0;
               cnt        <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  mem_mem_ena <= 1'b0;
                  if (last_is_dbg) begin
                     dbg_ready <= 1'b1;
                     if (!lat_we) begin
                        dbg_rdata <= mem_rdata;
                     end
                  end else begin
                     cpu_ready <= 1'b1;
                     if (!lat_we) begin
                        cpu_rdata <= mem_rdata;
                     end
                  end
                  state <= DONE;
               end
            end

            DONE: begin
               if (!owner_req) begin
                  cpu_ready <= 1'b0;
                  dbg_ready <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               mem_mem_ena <= 1'b0;
               mem_wr_ena  <= 1'b0;
               cpu_ready   <= 1'b0;
               dbg_ready   <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic        cpu_ready, dbg_ready;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_mem_ena, mem_wr_ena, busy, grant_owner;

   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RD_LATENCY(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .dbg_req     (dbg_req),
      .dbg_we      (dbg_we),
      .dbg_addr    (dbg_addr),
      .dbg_wdata   (dbg_wdata),
      .dbg_rdata   (dbg_rdata),
      .dbg_ready   (dbg_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_mem_ena (mem_mem_ena),
      .mem_wr_ena  (mem_wr_ena),
      .busy        (busy),
      .grant_owner (grant_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: preload during reset, registered read one edge after enable
   always @(posedge clk) begin
      if (!reset) begin
         mem[16'h0010] <= 16'h1234;
         mem[16'h0020] <= 16'h5678;
         mem_rdata     <= 16'h0000;
      end else if (mem_mem_ena) begin
         if (mem_wr_ena) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (!(cpu_ready || dbg_ready) && cycles < 20) begin
         step();
         cycles++;
      end
      if (!(cpu_ready || dbg_ready)) check("ready_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0020; dbg_wdata = 16'h0000;

      // Reset with both requests high
      repeat (3) step();
      check("rst_mem_ena", mem_mem_ena, 0);
      check("rst_wr_ena", mem_wr_ena, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_dbg_ready", dbg_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_owner, 1);
      check("rst_cpu_rdata", cpu_rdata, 0);

      // Release: cpu wins the first tie, reads 0x0010
      reset = 1'b1;
      step();
      check("rd_grant_cpu", grant_owner, 0);
      check("rd_busy", busy, 1);
      check("rd_ena_c1", mem_mem_ena, 1);
      check("rd_addr_c1", mem_addr, 16'h0010);
      check("rd_wr_c1", mem_wr_ena, 0);
      step();
      check("rd_ena_c2", mem_mem_ena, 1);
      check("rd_ready_c2", cpu_ready, 0);
      step();
      check("rd_ena_c3", mem_mem_ena, 0);
      check("rd_ready_c3", cpu_ready, 1);
      check("rd_data", cpu_rdata, 16'h1234);
      check("rd_dbg_ready", dbg_ready, 0);
      step();
      check("rd_ready_held", cpu_ready, 1);
      cpu_req = 1'b0;
      step();
      check("rd_ready_drop", cpu_ready, 0);
      check("rd_busy_drop", busy, 0);

      // Pending debug read is served next
      wait_ready(cyc);
      check("dbg_rd_lat", cyc, 3);
      check("dbg_rd_ready", dbg_ready, 1);
      check("dbg_rd_grant", grant_owner, 1);
      check("dbg_rd_data", dbg_rdata, 16'h5678);
      check("dbg_rd_cpu_keep", cpu_rdata, 16'h1234);
      dbg_req = 1'b0;
      step();

      // Debug write 0xBEEF to 0x3000
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h3000; dbg_wdata = 16'hBEEF;
      step();
      check("wr_ena", mem_mem_ena, 1);
      check("wr_strobe", mem_wr_ena, 1);
      check("wr_addr", mem_addr, 16'h3000);
      check("wr_data", mem_wdata, 16'hBEEF);
      step();
      check("wr_strobe_off", mem_wr_ena, 0);
      check("wr_ena_off", mem_mem_ena, 0);
      check("wr_ready", dbg_ready, 1);
      check("wr_rdata_keep", dbg_rdata, 16'h5678);
      dbg_req = 1'b0; dbg_we = 1'b0;
      step();

      // Readback through the cpu port
      cpu_req = 1'b1; cpu_addr = 16'h3000;
      wait_ready(cyc);
      check("rb_lat", cyc, 3);
      check("rb_ready", cpu_ready, 1);
      check("rb_data", cpu_rdata, 16'hBEEF);
      cpu_req = 1'b0;
      step();

      // Lone debug read so the debug port owns last before contention
      dbg_req = 1'b1; dbg_addr = 16'h0020;
      wait_ready(cyc);
      check("pre_ready", dbg_ready, 1);
      dbg_req = 1'b0;
      step();

      // Contention: both held, owner does a one-cycle four-phase drop
      cpu_addr = 16'h0010;
      cpu_req = 1'b1; dbg_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready(cyc);
         check("ct_lat", cyc, 3);
         check("ct_grant", grant_owner, i % 2);
         if (i % 2 == 0) begin
            check("ct_cpu_ready", cpu_ready, 1);
            check("ct_dbg_idle", dbg_ready, 0);
            check("ct_cpu_data", cpu_rdata, 16'h1234);
            cpu_req = 1'b0;
            step();
            cpu_req = 1'b1;
         end else begin
            check("ct_dbg_ready", dbg_ready, 1);
            check("ct_cpu_idle", cpu_ready, 0);
            check("ct_dbg_data", dbg_rdata, 16'h5678);
            dbg_req = 1'b0;
            step();
            dbg_req = 1'b1;
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (5) step();
      check("ct_idle", busy, 0);

      // Input hold: address change during the access is ignored
      cpu_req = 1'b1; cpu_addr = 16'h0010;
      step();
      cpu_addr = 16'h0020;
      check("hold_addr_c1", mem_addr, 16'h0010);
      step();
      check("hold_addr_c2", mem_addr, 16'h0010);
      check("hold_ena_c2", mem_mem_ena, 1);
      step();
      check("hold_ready", cpu_ready, 1);
      check("hold_data", cpu_rdata, 16'h1234);
      cpu_req = 1'b0;
      step();

      // Reset in the first access cycle of a write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hAAAA;
      step();
      check("mr_strobe", mem_wr_ena, 1);
      reset = 1'b0;
      step();
      check("mr_strobe_off", mem_wr_ena, 0);
      check("mr_ena_off", mem_mem_ena, 0);
      check("mr_busy", busy, 0);
      check("mr_ready", cpu_ready, 0);
      check("mr_grant", grant_owner, 1);
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
      step();
      check("mr_no_ready", cpu_ready, 0);

      // Arbiter works normally after the abandoned access
      dbg_req = 1'b1; dbg_addr = 16'h0010;
      wait_ready(cyc);
      check("post_lat", cyc, 3);
      check("post_ready", dbg_ready, 1);
      check("post_data", dbg_rdata, 16'h1234);
      dbg_req = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
